// File: rtl/fa4bit_using_fa1bit_pkg.sv
// rtl/fa4bit_using_fa1bit_pkg.sv - shared width constant for the 4-bit ripple adder
package fa4bit_using_fa1bit_pkg;
  localparam int ADDER_W = 4;
endpackage

// File: rtl/fa4bit_using_fa1bit_fa_1bit.sv
// rtl/fa4bit_using_fa1bit_fa_1bit.sv - combinational 1-bit full adder cell
module fa_1bit (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);
  logic p;

  assign p    = a ^ b;
  assign sum  = p ^ cin;
  assign cout = (a & b) | (cin & p);
endmodule

// File: rtl/fa4bit_using_fa1bit.sv
// rtl/fa4bit_using_fa1bit.sv - 4-bit ripple-carry adder from fa_1bit cells, optional output register
module fa4bit_using_fa1bit
  import fa4bit_using_fa1bit_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter bit OUT_REG = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);
  logic [ADDER_W:0]   c;
  logic [ADDER_W-1:0] s;

  if (WIDTH != ADDER_W) begin : g_width_check
    $error("fa4bit_using_fa1bit: only WIDTH=4 is supported");
  end

  assign c[0] = cin;

  for (genvar i = 0; i < ADDER_W; i++) begin : g_bit
    fa_1bit u_fa (
      .a    (a[i]),
      .b    (b[i]),
      .cin  (c[i]),
      .sum  (s[i]),
      .cout (c[i+1])
    );
  end

  if (OUT_REG) begin : g_reg
    // Reset discards whatever result is in flight this edge.
    always_ff @(posedge clk) begin
      if (rst) begin
        sum  <= '0;
        cout <= 1'b0;
      end else begin
        sum  <= s;
        cout <= c[ADDER_W];
      end
    end
  end else begin : g_comb
    assign sum  = s;
    assign cout = c[ADDER_W];
  end
endmodule

// File: tb/tb_fa4bit_using_fa1bit.sv
// tb/tb_fa4bit_using_fa1bit.sv - self-checking bench for the registered 4-bit adder
module tb_fa4bit_using_fa1bit;
  logic       clk;
  logic       rst;
  logic [3:0] a;
  logic [3:0] b;
  logic       cin;
  logic [3:0] sum;
  logic       cout;

  int n_checks;
  int n_fail;

  fa4bit_using_fa1bit #(.WIDTH(4), .OUT_REG(1'b1)) dut (
    .clk  (clk),
    .rst  (rst),
    .a    (a),
    .b    (b),
    .cin  (cin),
    .sum  (sum),
    .cout (cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [4:0] model(input logic [8:0] v);
    int total;
    total = int'(v[8:5]) + int'(v[4:1]) + int'(v[0]);
    return 5'(total);
  endfunction

  task automatic check(input string tag, input logic [4:0] obs, input logic [4:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed {cout,sum}=%b expected %b", tag, obs, exp);
    end
  endtask

  // Drive at the falling edge, sample 1 time unit after the following rising edge.
  task automatic step(input logic [8:0] v, input logic r, input string tag);
    @(negedge clk);
    {a, b, cin} = v;
    rst = r;
    @(posedge clk);
    #1;
    check(tag, {cout, sum}, r ? 5'd0 : model(v));
  endtask

  initial begin
    logic [8:0] dir [8];
    logic [8:0] v;
    n_checks = 0;
    n_fail   = 0;
    rst = 1'b1;
    a   = 4'hF;
    b   = 4'hF;
    cin = 1'b1;

    step(9'h1FF, 1'b1, "reset_hold_0");
    step(9'h1FF, 1'b1, "reset_hold_1");
    step(9'h1FF, 1'b0, "reset_release");
    check("release_const", {cout, sum}, 5'b1_1111);

    dir = '{9'd0, 9'd2, 9'd4, 9'd17, 9'd400, 9'd509, 9'd328, {4'hF, 4'h0, 1'b1}};
    foreach (dir[i]) step(dir[i], 1'b0, $sformatf("directed_%0d", dir[i]));
    step(9'd400, 1'b0, "carry_c8");
    check("carry_c8_const", {cout, sum}, 5'b1_0100);
    step({4'hF, 4'h0, 1'b1}, 1'b0, "full_ripple");
    check("full_ripple_const", {cout, sum}, 5'b1_0000);

    for (int i = 0; i < 512; i++) step(9'(i), 1'b0, $sformatf("sweep_%0d", i));

    for (int i = 0; i < 40; i++) begin
      v = 9'($urandom_range(511));
      step(v, (i == 20), $sformatf("stream_%0d", i));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
